// File: rtl/bus_slave_responder.sv
// Bus responder: accepts one read/write request at a time, stores words in an internal
// buffer and returns one response per request over a valid/ready channel.
module bus_slave_responder #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_write,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic              busy
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((RD_LAT > 0) ? RD_LAT - 1 : 0);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_next;

  logic [DATA_W-1:0]  r_buff [DEPTH];
  logic [IDX_W-1:0]   r_addr;
  logic               r_write;
  logic               r_err;
  logic [DATA_W-1:0]  r_data;
  logic [CNT_W-1:0]   r_cnt;

  logic               w_accept;
  logic               w_in_range;
  logic [IDX_W-1:0]   w_idx;
  logic               w_buf_we;
  logic               w_rd_now;

  // Full-width unsigned compare: upper address bits never alias into the buffer.
  assign w_in_range = (req_addr < ADDR_W'(DEPTH));
  assign w_idx      = req_addr[IDX_W-1:0];
  assign w_accept   = req_valid && (r_state == ST_IDLE);
  assign w_buf_we   = w_accept && req_write && w_in_range;
  assign w_rd_now   = w_accept && !req_write && w_in_range && (RD_LAT == 0);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (req_write || !w_in_range || (RD_LAT == 0)) begin
            w_state_next = ST_RESP;
          end else begin
            w_state_next = ST_ACCESS;
          end
        end
      end
      ST_ACCESS: begin
        if (r_cnt == '0) begin
          w_state_next = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Output logic: handshake flags come straight from state so reset drops them at once.
  always_comb begin
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    busy      = 1'b1;
    case (r_state)
      ST_IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
      end
      default: begin
        req_ready = 1'b0;
        rsp_valid = 1'b0;
      end
    endcase
  end

  // Transaction context and response payload, held stable through the RESP state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr  <= '0;
      r_write <= 1'b0;
      r_err   <= 1'b0;
      r_data  <= '0;
      r_cnt   <= '0;
    end else begin
      if (w_accept) begin
        r_addr  <= w_idx;
        r_write <= req_write;
        r_err   <= !w_in_range;
        r_cnt   <= CNT_INIT;
        if (w_rd_now) begin
          r_data <= r_buff[w_idx];
        end else begin
          r_data <= '0;
        end
      end else if (r_state == ST_ACCESS) begin
        if (r_cnt == '0) begin
          r_data <= r_buff[r_addr];
        end else begin
          r_cnt <= r_cnt - 1'b1;
        end
      end
    end
  end

  // Word buffer; reset clears every word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_buff[i] <= '0;
      end
    end else if (w_buf_we) begin
      r_buff[w_idx] <= req_data;
    end
  end

  assign rsp_write = r_write;
  assign rsp_data  = r_data;
  assign rsp_err   = r_err;

endmodule

// File: tb/tb_bus_slave_responder.sv
// Scoreboard bench for bus_slave_responder: expected responses are queued at request
// acceptance and compared when the responder presents them.
module tb_bus_slave_responder;

  localparam int RD_LAT = 2;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_write;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        busy;

  typedef struct {
    logic        wr;
    logic [31:0] data;
    logic        err;
    int          lat;
    int          acc;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mem [256];
  int          cyc = 0;
  int          n_vec = 0;
  int          n_miss = 0;
  bit          in_rsp = 0;

  bus_slave_responder #(
    .ADDR_W(32), .DATA_W(32), .DEPTH(256), .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    int   n;
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_data  = d;
    n = 0;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      chk("req_accept_timeout", 0, 1);
      req_valid = 1'b0;
      return;
    end
    e.wr   = w;
    e.acc  = cyc;
    e.err  = (a >= 32'd256);
    e.data = 32'h0;
    e.lat  = 1;
    if (!e.err) begin
      if (w) begin
        mem[a[7:0]] = d;
      end else begin
        e.data = mem[a[7:0]];
        e.lat  = 1 + RD_LAT;
      end
    end
    sb.push_back(e);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      chk("drain_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  // Response monitor: samples shortly after the falling edge, pops on handshake.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        in_rsp = 0;
      end else if (rsp_valid) begin
        if (sb.size() == 0) begin
          chk("spurious_rsp", 1, 0);
        end else begin
          if (!in_rsp) chk("rsp_latency", cyc - sb[0].acc, sb[0].lat);
          in_rsp = 1;
          chk("rsp_write", rsp_write, sb[0].wr);
          chk("rsp_data", rsp_data, sb[0].data);
          chk("rsp_err", rsp_err, sb[0].err);
          if (rsp_ready) begin
            void'(sb.pop_front());
            in_rsp = 0;
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=%0d exp=0", sb.size());
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    foreach (mem[i]) mem[i] = 32'h0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = 32'h0;
    req_data  = 32'h0;
    rsp_ready = 1'b1;
    rst_n     = 1'b1;
    #1 rst_n  = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_write", rsp_write, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    @(negedge clk);

    do_req(1'b0, 32'h05, 32'h0);
    drain();
    do_req(1'b1, 32'h10, 32'hDEADBEEF);
    do_req(1'b0, 32'h10, 32'h0);
    drain();

    // Out-of-range and boundary addresses
    do_req(1'b1, 32'd256, 32'h1234);
    do_req(1'b0, 32'd0, 32'h0);
    do_req(1'b1, 32'hFFFF_FFFF, 32'h1);
    do_req(1'b0, 32'hFFFF_FFFF, 32'h0);
    do_req(1'b1, 32'd255, 32'h5555_AAAA);
    do_req(1'b0, 32'd255, 32'h0);
    drain();

    // Response back-pressure
    rsp_ready = 1'b0;
    do_req(1'b0, 32'h10, 32'h0);
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("hold_rsp_valid", rsp_valid, 1);
    repeat (5) begin
      chk("hold_req_ready", req_ready, 0);
      chk("hold_busy", busy, 1);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("req_ready_after_hs", req_ready, 1);
    chk("rsp_valid_after_hs", rsp_valid, 0);
    drain();

    // Back-to-back writes then read-back
    for (int i = 0; i < 4; i++) do_req(1'b1, 32'(i), 32'hA0 + 32'(i));
    for (int i = 0; i < 4; i++) do_req(1'b0, 32'(i), 32'h0);
    drain();

    // Random mix, mostly in range with occasional out-of-range addresses
    repeat (24) begin
      logic        w;
      logic [31:0] a;
      w = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) a = 32'($urandom_range(256, 300));
      else a = 32'($urandom_range(0, 31));
      do_req(w, a, $urandom);
    end
    drain();

    // Reset while the read is in its access phase
    do_req(1'b0, 32'h10, 32'h0);
    chk("pre_rst_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_rsp_valid", rsp_valid, 0);
    chk("midrst_req_ready", req_ready, 1);
    chk("midrst_busy", busy, 0);
    sb.delete();
    foreach (mem[i]) mem[i] = 32'h0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("no_stale_rsp", rsp_valid, 0);
    end
    do_req(1'b0, 32'h10, 32'h0);
    do_req(1'b0, 32'd2, 32'h0);
    drain();

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
